prio_encoder_q: RTL and testbench

- Parametrised, registered successor to the team's 8-to-3 encoder.
- Captures request pulses on N lines into a sticky pending vector.
- Presents one pending index at a time on a valid/ready output port, chosen by fixed priority or round-robin.
- Used as the interrupt/event front-end ahead of the controller, where the combinational encoder dropped simultaneous and back-to-back events.

---
 rtl/encoder_pkg.sv | 21 ++
 rtl/prio_encoder_q_if.sv | 23 ++
 rtl/prio_pick.sv | 52 +++++
 rtl/prio_encoder_q.sv | 85 ++++++++
 tb/tb_prio_encoder_q.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/encoder_pkg.sv
// rtl/encoder_pkg.sv - shared mode constants and width helpers for the priority encoder
package encoder_pkg;

  localparam int MODE_FIXED = 0;
  localparam int MODE_RR    = 1;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  // A single request line still needs a one-bit index port.
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/prio_encoder_q_if.sv
// rtl/prio_encoder_q_if.sv - valid/ready index output port of the priority encoder
interface prio_encoder_q_if #(
  parameter int N = 8
);
  localparam int IDX_W = encoder_pkg::idx_w(N);

  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] out_idx;

  modport master (
    output out_valid,
    output out_idx,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_idx,
    output out_ready
  );

endinterface

// File: rtl/prio_pick.sv
// rtl/prio_pick.sv - combinational selector: highest set index, or round-robin after ptr
module prio_pick
  import encoder_pkg::*;
#(
  parameter int  N     = 8,
  parameter int  MODE  = MODE_FIXED,
  localparam int IDX_W = idx_w(N)
) (
  input  logic [N-1:0]     cand,
  input  logic [IDX_W-1:0] ptr,
  output logic             any,
  output logic [IDX_W-1:0] idx
);

  assign any = |cand;

  generate
    if (MODE == MODE_RR && N > 1) begin : g_rr
      logic [N-1:0]   after_ptr;
      logic [2*N-1:0] dbl;

      always_comb begin
        after_ptr = '0;
        for (int i = 0; i < N; i++) begin
          after_ptr[i] = (32'(i) > 32'(ptr));
        end
      end

      // Lower half holds only lines after ptr; upper half is the full set, so
      // the lowest set bit overall is the next line after ptr with wrap.
      assign dbl = {cand, cand & after_ptr};

      always_comb begin
        idx = '0;
        for (int i = 2 * N - 1; i >= 0; i--) begin
          if (dbl[i]) idx = (i >= N) ? IDX_W'(i - N) : IDX_W'(i);
        end
      end
    end else begin : g_fixed
      logic unused_ptr;
      assign unused_ptr = ^ptr;

      always_comb begin
        idx = '0;
        for (int i = 0; i < N; i++) begin
          if (cand[i]) idx = IDX_W'(i);
        end
      end
    end
  endgenerate

endmodule

// File: rtl/prio_encoder_q.sv
// rtl/prio_encoder_q.sv - sticky pending request capture with one-at-a-time valid/ready index output
module prio_encoder_q
  import encoder_pkg::*;
#(
  parameter int N    = 8,
  parameter int MODE = MODE_FIXED
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [N-1:0]     req_in,
  input  logic [N-1:0]     req_mask,
  prio_encoder_q_if.master out_if,
  output logic [N-1:0]     pend_vec,
  output logic             coalesce
);

  localparam int IDX_W = idx_w(N);

  logic             valid_q;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] ptr_eff;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;
  logic             accept;
  logic             load;
  logic [N-1:0]     clr;
  logic [N-1:0]     set;
  logic [N-1:0]     pend_next;
  logic [N-1:0]     cand;
  logic             coal_next;

  assign accept = valid_q && out_if.out_ready;
  assign load   = !valid_q || accept;

  always_comb begin
    clr = '0;
    for (int i = 0; i < N; i++) begin
      clr[i] = accept && (idx_q == IDX_W'(i));
    end
  end

  // A set on the bit being cleared re-arms it as a fresh event.
  assign set       = en ? req_in : '0;
  assign pend_next = (pend_vec & ~clr) | set;
  assign coal_next = |(set & pend_vec & ~clr);

  // Loading only happens with nothing held or the held index just accepted,
  // so the held line never needs excluding from the candidates.
  assign cand    = pend_next & ~req_mask;
  assign ptr_eff = accept ? idx_q : ptr_q;

  prio_pick #(
    .N    (N),
    .MODE (MODE)
  ) u_pick (
    .cand (cand),
    .ptr  (ptr_eff),
    .any  (pick_any),
    .idx  (pick_idx)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_vec <= '0;
      coalesce <= 1'b0;
      valid_q  <= 1'b0;
      idx_q    <= '0;
      ptr_q    <= IDX_W'(N - 1);
    end else begin
      pend_vec <= pend_next;
      coalesce <= coal_next;
      if (load) begin
        valid_q <= pick_any;
        if (pick_any) idx_q <= pick_idx;
      end
      if (accept) ptr_q <= idx_q;
    end
  end

  assign out_if.out_valid = valid_q;
  assign out_if.out_idx   = idx_q;

endmodule

// File: tb/tb_prio_encoder_q.sv
// tb/tb_prio_encoder_q.sv - scoreboard bench for fixed-priority and round-robin encoder instances
module tb_prio_encoder_q;
  import encoder_pkg::*;

  localparam int N  = 8;
  localparam int IW = idx_w(N);

  typedef struct packed {
    logic          valid;
    logic [IW-1:0] idx;
    logic [N-1:0]  pend;
    logic          coal;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en;
  logic         out_ready;
  logic [N-1:0] req_in;
  logic [N-1:0] req_mask;
  logic [N-1:0] pend_f, pend_r;
  logic         coal_f, coal_r;

  int vectors     = 0;
  int miscompares = 0;

  exp_t q_f[$];
  exp_t q_r[$];
  int   log_f[$];
  int   log_r[$];

  bit m_pend[2][N];
  bit m_valid[2];
  int m_idx[2];
  int m_ptr[2];
  bit m_coal[2];

  always #5 clk = ~clk;

  prio_encoder_q_if #(.N(N)) if_f ();
  prio_encoder_q_if #(.N(N)) if_r ();

  assign if_f.out_ready = out_ready;
  assign if_r.out_ready = out_ready;

  prio_encoder_q #(.N(N), .MODE(MODE_FIXED)) dut_f (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .req_in   (req_in),
    .req_mask (req_mask),
    .out_if   (if_f),
    .pend_vec (pend_f),
    .coalesce (coal_f)
  );

  prio_encoder_q #(.N(N), .MODE(MODE_RR)) dut_r (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .req_in   (req_in),
    .req_mask (req_mask),
    .out_if   (if_r),
    .pend_vec (pend_r),
    .coalesce (coal_r)
  );

  // Reference: events per line, one grant per accept, candidates scanned in priority order.
  task automatic model_step(input int m);
    bit acc;
    bit ncoal;
    bit np[N];
    int held;
    int pick;
    if (!rst_n) begin
      for (int i = 0; i < N; i++) m_pend[m][i] = 1'b0;
      m_valid[m] = 1'b0;
      m_idx[m]   = 0;
      m_ptr[m]   = N - 1;
      m_coal[m]  = 1'b0;
      return;
    end
    held  = m_idx[m];
    acc   = m_valid[m] && out_ready;
    ncoal = 1'b0;
    for (int i = 0; i < N; i++) begin
      bit still;
      bit ev;
      still = m_pend[m][i] && !(acc && held == i);
      ev    = en && req_in[i];
      if (still && ev) ncoal = 1'b1;
      np[i] = still || ev;
    end
    if (acc) m_ptr[m] = held;
    if (!m_valid[m] || acc) begin
      pick = -1;
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m == 0) ? (N - 1 - k) : ((m_ptr[m] + 1 + k) % N);
        if (pick < 0 && np[j] && !req_mask[j]) pick = j;
      end
      m_valid[m] = (pick >= 0);
      if (pick >= 0) m_idx[m] = pick;
    end
    for (int i = 0; i < N; i++) m_pend[m][i] = np[i];
    m_coal[m] = ncoal;
  endtask

  function automatic exp_t model_exp(input int m);
    exp_t e;
    e.valid = m_valid[m];
    e.idx   = IW'(m_idx[m]);
    for (int i = 0; i < N; i++) e.pend[i] = m_pend[m][i];
    e.coal  = m_coal[m];
    return e;
  endfunction

  task automatic drive(input logic r_v, input logic e_v, input logic [N-1:0] rq_v,
                       input logic [N-1:0] mk_v, input logic rdy_v);
    @(negedge clk);
    rst_n     = r_v;
    en        = e_v;
    req_in    = rq_v;
    req_mask  = mk_v;
    out_ready = rdy_v;
    if (rst_n && if_f.out_valid && out_ready) log_f.push_back(int'(if_f.out_idx));
    if (rst_n && if_r.out_valid && out_ready) log_r.push_back(int'(if_r.out_idx));
    model_step(0);
    model_step(1);
    q_f.push_back(model_exp(0));
    q_r.push_back(model_exp(1));
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b1, 1'b1, '0, '0, 1'b1);
  endtask

  task automatic check(input string name, input exp_t e, input logic v, input logic [IW-1:0] ix,
                       input logic [N-1:0] p, input logic c);
    vectors++;
    if (v !== e.valid || ix !== e.idx || p !== e.pend || c !== e.coal) begin
      miscompares++;
      $display("FAIL %s @%0t: got valid=%0b idx=%0d pend=%h coal=%0b, expected valid=%0b idx=%0d pend=%h coal=%0b",
               name, $time, v, ix, p, c, e.valid, e.idx, e.pend, e.coal);
    end
  endtask

  task automatic check_log(input string name, input int m, input int exp_seq[10],
                           input int len, input bit exact);
    int    got[$];
    bit    ok;
    string s;
    if (m == 0) got = log_f;
    else        got = log_r;
    vectors++;
    ok = exact ? (got.size() == len) : (got.size() >= len);
    for (int i = 0; i < len && i < got.size(); i++) begin
      if (got[i] != exp_seq[i]) ok = 1'b0;
    end
    if (!ok) begin
      miscompares++;
      s = "";
      for (int i = 0; i < got.size() && i < 12; i++) s = {s, $sformatf(" %0d", got[i])};
      $display("FAIL %s: got %0d grants [%s ], required %0d leading grants starting %0d", name,
               got.size(), s, len, exp_seq[0]);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q_f.size() > 0) check("fixed", q_f.pop_front(), if_f.out_valid, if_f.out_idx, pend_f, coal_f);
      if (q_r.size() > 0) check("rr", q_r.pop_front(), if_r.out_valid, if_r.out_idx, pend_r, coal_r);
    end
  end

  initial begin
    rst_n     = 1'b0;
    en        = 1'b1;
    req_in    = '1;
    req_mask  = '0;
    out_ready = 1'b1;

    repeat (2) drive(1'b0, 1'b1, 8'hFF, '0, 1'b1);
    idle(3);

    log_f.delete(); log_r.delete();
    drive(1'b1, 1'b1, 8'h92, '0, 1'b1);
    idle(5);
    check_log("burst_fixed", 0, '{7, 4, 1, 0, 0, 0, 0, 0, 0, 0}, 3, 1'b1);
    check_log("burst_rr", 1, '{1, 4, 7, 0, 0, 0, 0, 0, 0, 0}, 3, 1'b1);

    log_f.delete(); log_r.delete();
    drive(1'b1, 1'b1, 8'h10, '0, 1'b0);
    drive(1'b1, 1'b1, 8'h00, '0, 1'b0);
    drive(1'b1, 1'b1, 8'h80, '0, 1'b0);
    drive(1'b1, 1'b1, 8'h00, '0, 1'b0);
    idle(4);
    check_log("backpressure_fixed", 0, '{4, 7, 0, 0, 0, 0, 0, 0, 0, 0}, 2, 1'b1);
    check_log("backpressure_rr", 1, '{4, 7, 0, 0, 0, 0, 0, 0, 0, 0}, 2, 1'b1);

    log_f.delete(); log_r.delete();
    repeat (10) drive(1'b1, 1'b1, 8'hFF, '0, 1'b1);
    idle(12);
    check_log("rr_rotation", 1, '{0, 1, 2, 3, 4, 5, 6, 7, 0, 1}, 10, 1'b0);
    check_log("fixed_hog", 0, '{7, 7, 7, 7, 7, 7, 7, 7, 7, 0}, 9, 1'b0);

    log_f.delete(); log_r.delete();
    drive(1'b1, 1'b1, 8'h08, '0, 1'b0);
    drive(1'b1, 1'b1, 8'h00, '0, 1'b0);
    drive(1'b1, 1'b1, 8'h08, '0, 1'b0);
    drive(1'b1, 1'b1, 8'h00, '0, 1'b0);
    drive(1'b1, 1'b1, 8'h08, '0, 1'b1);
    idle(3);
    check_log("coalesce_fixed", 0, '{3, 3, 0, 0, 0, 0, 0, 0, 0, 0}, 2, 1'b1);
    check_log("coalesce_rr", 1, '{3, 3, 0, 0, 0, 0, 0, 0, 0, 0}, 2, 1'b1);

    log_f.delete(); log_r.delete();
    drive(1'b1, 1'b1, 8'h01, '0, 1'b0);
    repeat (2) drive(1'b1, 1'b0, 8'hFF, '0, 1'b0);
    idle(2);
    drive(1'b1, 1'b1, 8'h20, 8'h20, 1'b1);
    repeat (2) drive(1'b1, 1'b1, 8'h00, 8'h20, 1'b1);
    idle(3);
    check_log("mask_en_fixed", 0, '{0, 5, 0, 0, 0, 0, 0, 0, 0, 0}, 2, 1'b1);
    check_log("mask_en_rr", 1, '{0, 5, 0, 0, 0, 0, 0, 0, 0, 0}, 2, 1'b1);

    for (int c = 0; c < 400; c++) begin
      drive(($urandom_range(0, 99) != 0),
            ($urandom_range(0, 7) != 0),
            N'($urandom & $urandom),
            ($urandom_range(0, 3) == 0) ? N'($urandom) : N'(0),
            ($urandom_range(0, 2) != 0));
    end
    idle(4);

    repeat (2) @(posedge clk);
    #2;
    vectors++;
    if (q_f.size() != 0 || q_r.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d/%0d unchecked entries, required 0/0", q_f.size(), q_r.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
